// File: rtl/pulse_train_gen.sv
// ============================================================================
//  Module   : pulse_train_gen
//  Purpose  : Emits a burst of N programmable-width pulses on each qualified
//             rising edge of trigger. PULSE_TRAIN_RETRIG_EN allows restarts
//             while busy.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [NUM_W-1:0] n_pulses,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_trig_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_m1;
  logic [CNT_W-1:0] r_low_m1;
  logic [NUM_W-1:0] r_num;

  logic             w_start_evt;
  logic             w_accept;
  logic [CNT_W-1:0] w_high_m1;
  logic [CNT_W-1:0] w_low_m1;

  assign w_start_evt = trigger & ~r_trig_d;

  // A width of zero behaves as one cycle, so the reload value saturates at 0.
  assign w_high_m1 = (high_cycles == '0) ? '0 : high_cycles - CNT_W'(1);
  assign w_low_m1  = (low_cycles  == '0) ? '0 : low_cycles  - CNT_W'(1);

`ifdef PULSE_TRAIN_RETRIG_EN
  assign w_accept = w_start_evt && (n_pulses != '0);
`else
  assign w_accept = w_start_evt && (n_pulses != '0) && (r_state == S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_trig_d    <= 1'b1;
      r_cnt       <= '0;
      r_high_m1   <= '0;
      r_low_m1    <= '0;
      r_num       <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      r_trig_d <= trigger;
      done     <= 1'b0;
      if (w_accept) begin
        r_state     <= S_HIGH;
        r_cnt       <= w_high_m1;
        r_high_m1   <= w_high_m1;
        r_low_m1    <= w_low_m1;
        r_num       <= n_pulses;
        pulse_out   <= 1'b1;
        busy        <= 1'b1;
        pulse_count <= '0;
      end else begin
        case (r_state)
          S_HIGH: begin
            if (r_cnt == '0) begin
              r_state     <= S_LOW;
              r_cnt       <= r_low_m1;
              pulse_out   <= 1'b0;
              pulse_count <= pulse_count + NUM_W'(1);
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_LOW: begin
            if (r_cnt == '0) begin
              // The trailing low gap always completes before the burst ends.
              if (pulse_count < r_num) begin
                r_state   <= S_HIGH;
                r_cnt     <= r_high_m1;
                pulse_out <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
//  Module   : tb_pulse_train_gen
//  Purpose  : Self-checking bench for pulse_train_gen (burst-timing model).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [7:0]  n_pulses;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_count;

  pulse_train_gen dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .n_pulses    (n_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

`ifdef PULSE_TRAIN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // Reference: a burst is fully described by its start edge and latched
  // config; outputs follow from the elapsed edge count by arithmetic.
  longint cyc = 0;
  longint m_s, m_n, m_h, m_l, m_t;
  bit     m_has = 1'b0;
  bit     m_td  = 1'b1;
  bit     m_valid = 1'b0;
  bit     e_pulse, e_busy, e_done;
  longint e_cnt;

  always @(posedge clk) begin
    longint k, p, ph;
    bit     st, busy_before;
    cyc++;
    if (rst) begin
      m_td  = 1'b1;
      m_has = 1'b0;
    end else begin
      st   = trigger && !m_td;
      m_td = trigger;
      busy_before = m_has && ((cyc - 1 - m_s) < m_t);
      if (st && n_pulses != 0 && (!busy_before || RETRIG)) begin
        m_s   = cyc;
        m_n   = n_pulses;
        m_h   = (high_cycles == 0) ? 1 : high_cycles;
        m_l   = (low_cycles  == 0) ? 1 : low_cycles;
        m_t   = m_n * (m_h + m_l);
        m_has = 1'b1;
      end
    end
    if (!m_has) begin
      e_pulse = 0; e_busy = 0; e_done = 0; e_cnt = 0;
    end else begin
      k = cyc - m_s;
      p = m_h + m_l;
      if (k < m_t) begin
        ph      = k % p;
        e_busy  = 1;
        e_done  = 0;
        e_pulse = (ph < m_h);
        e_cnt   = k / p + ((ph >= m_h) ? 1 : 0);
      end else begin
        e_busy  = 0;
        e_pulse = 0;
        e_done  = (k == m_t);
        e_cnt   = m_n;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model pulse_out",   pulse_out,   e_pulse);
      check("model busy",        busy,        e_busy);
      check("model done",        done,        e_done);
      check("model pulse_count", pulse_count, e_cnt % 256);
    end
  end

  // Recording window for the directed scenarios.
  bit     rec_p [0:127];
  bit     rec_b [0:127];
  bit     rec_d [0:127];
  int     rec_c [0:127];
  int     busy_n, done_n, done_at, high_n;

  task automatic start_burst(input int n, input int h, input int l);
    @(posedge clk); #1 trigger = 1'b0;
    @(posedge clk); #1;
    n_pulses    = 8'(n);
    high_cycles = 16'(h);
    low_cycles  = 16'(l);
    trigger     = 1'b1;
  endtask

  // Sample i is taken in the cycle after edge t+i; actions land after edge t+i.
  task automatic observe(input int w, input int kind);
    busy_n = 0; done_n = 0; done_at = -1; high_n = 0;
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
      case (kind)
        1: if (i == 4) high_cycles = 16'd8;
        2: begin
             if (i == 5) rst = 1'b1;
             if (i == 6) rst = 1'b0;
           end
        3: begin
             if (i == 10) trigger = 1'b0;
             if (i == 19) trigger = 1'b1;
           end
        4: begin
             if (i == 0) trigger = 1'b0;
             if (i == 2) trigger = 1'b1;
           end
        default: ;
      endcase
      @(negedge clk);
      rec_p[i] = pulse_out;
      rec_b[i] = busy;
      rec_d[i] = done;
      rec_c[i] = int'(pulse_count);
      busy_n += int'(busy);
      high_n += int'(pulse_out);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
    end
  endtask

  function automatic logic [14:0] pat15();
    logic [14:0] v = '0;
    for (int i = 0; i < 15; i++) v = {v[13:0], rec_p[i]};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; trigger = 1'b1;
    n_pulses = 8'd3; high_cycles = 16'd2; low_cycles = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pulse_out", pulse_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pulse_count", pulse_count, 0);

    // Trigger held high across reset release must not start a burst.
    @(posedge clk); #1 rst = 1'b0;
    observe(10, 0);
    check("held trigger busy cycles", busy_n, 0);

    start_burst(3, 2, 3);
    observe(20, 0);
    check("basic pattern", pat15(), 15'b110001100011000);
    check("basic busy cycles", busy_n, 15);
    check("basic done count", done_n, 1);
    check("basic done index", done_at, 15);
    check("basic first count", rec_c[0], 0);
    check("basic final count", rec_c[19], 3);

    start_burst(0, 2, 3);
    observe(10, 0);
    check("n0 busy cycles", busy_n, 0);
    check("n0 done count", done_n, 0);
    check("n0 count kept", rec_c[9], 3);

    start_burst(1, 0, 0);
    observe(6, 0);
    check("zero width busy cycles", busy_n, 2);
    check("zero width done index", done_at, 2);
    check("zero width high cycles", high_n, 1);
    check("zero width final count", rec_c[5], 1);

    start_burst(3, 2, 3);
    observe(20, 1);
    check("cfg change pattern", pat15(), 15'b110001100011000);
    check("cfg change busy cycles", busy_n, 15);
    start_burst(1, 8, 3);
    observe(14, 0);
    check("next burst busy cycles", busy_n, 11);
    check("next burst high cycles", high_n, 8);

    start_burst(4, 2, 3);
    observe(30, 2);
    check("rst mid pulse before", rec_p[5], 1);
    check("rst mid pulse_out", rec_p[6], 0);
    check("rst mid busy", rec_b[6], 0);
    check("rst mid count", rec_c[6], 0);
    check("rst mid done count", done_n, 0);
    check("rst mid busy cycles", busy_n, 6);

    start_burst(5, 4, 4);
    observe(75, 3);
    check("retrig busy cycles", busy_n, RETRIG ? 60 : 40);
    check("retrig done count", done_n, 1);
    check("retrig done index", done_at, RETRIG ? 60 : 40);

    start_burst(1, 1, 1);
    observe(10, 4);
    check("b2b done first", rec_d[2], 1);
    check("b2b busy restart", rec_b[3], 1);
    check("b2b done single", rec_d[3], 0);
    check("b2b pulse restart", rec_p[3], 1);
    check("b2b done count", done_n, 2);

    // Randomized traffic; the per-cycle model check does the work here.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 5) == 0) trigger = ~trigger;
      if ($urandom_range(0, 7) == 0) n_pulses = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) high_cycles = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) low_cycles = 16'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
